// File: rtl/regfile_mp.sv
// Multi-port scalar register file: bypassed combinational read lanes, two
// prioritized write ports, a busy scoreboard and a clear sequencer.
module regfile_mp_rd_lane #(
  parameter int DATA_W   = 36,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 0
) (
  input  logic              ready,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] mem_word,
  input  logic              busy_bit,
  input  logic              wr0_ok,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_ok,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  output logic [DATA_W-1:0] data,
  output logic              busy
);
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  logic live, hit0, hit1;

  // Out-of-range and hard-zero addresses read as an empty, never-busy register.
  assign live = ready && ({1'b0, addr} < DEPTH_L) && !(ZERO_REG != 0 && addr == '0);
  assign hit0 = wr0_ok && (wr0_addr == addr);
  assign hit1 = wr1_ok && (wr1_addr == addr);

  always_comb begin
    data = '0;
    if (live) begin
      if (hit1)      data = wr1_data;
      else if (hit0) data = wr0_data;
      else           data = mem_word;
    end
  end

  assign busy = live && busy_bit && !(hit0 || hit1);
endmodule

module regfile_mp #(
  parameter int DATA_W   = 36,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_start,
  output logic                     ready,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     res_en,
  input  logic [ADDR_W-1:0]        res_addr,
  output logic [DEPTH-1:0]         busy_vec
);
  localparam logic [0:0]        ST_CLEAR = 1'b0;
  localparam logic [0:0]        ST_READY = 1'b1;
  localparam logic [ADDR_W:0]   DEPTH_L  = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

  logic [0:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy_nxt;
  logic              wr0_ok, wr1_ok, res_ok;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_L) && !(ZERO_REG != 0 && a == '0);
  endfunction

  assign ready  = (state == ST_READY);
  assign wr0_ok = ready && wr0_en && addr_ok(wr0_addr);
  assign wr1_ok = ready && wr1_en && addr_ok(wr1_addr);
  assign res_ok = ready && res_en && addr_ok(res_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_CLEAR;
      ptr      <= '0;
      busy_vec <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == PTR_LAST) begin
            state <= ST_READY;
            ptr   <= '0;
          end
        end
        default: begin
          if (clr_start) begin
            state    <= ST_CLEAR;
            ptr      <= '0;
            busy_vec <= '0;
          end else begin
            busy_vec <= busy_nxt;
          end
        end
      endcase
    end
  end

  // Storage is unreset; the sequencer owns it while clearing. wr1 is applied
  // last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[ptr] <= '0;
    end else begin
      if (wr0_ok) mem[wr0_addr] <= wr0_data;
      if (wr1_ok) mem[wr1_addr] <= wr1_data;
    end
  end

  // A reservation beats a same-cycle writeback: the new producer keeps it busy.
  always_comb begin
    busy_nxt = busy_vec;
    for (int r = 0; r < DEPTH; r++) begin
      if (res_ok && res_addr == ADDR_W'(r))
        busy_nxt[r] = 1'b1;
      else if ((wr0_ok && wr0_addr == ADDR_W'(r)) || (wr1_ok && wr1_addr == ADDR_W'(r)))
        busy_nxt[r] = 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[i*ADDR_W +: ADDR_W];

    regfile_mp_rd_lane #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)
    ) u_lane (
      .ready    (ready),
      .addr     (a),
      .mem_word (mem[a]),
      .busy_bit (busy_vec[a]),
      .wr0_ok   (wr0_ok),
      .wr0_addr (wr0_addr),
      .wr0_data (wr0_data),
      .wr1_ok   (wr1_ok),
      .wr1_addr (wr1_addr),
      .wr1_data (wr1_data),
      .data     (rd_data[i*DATA_W +: DATA_W]),
      .busy     (rd_busy[i])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default instance and a ZERO_REG=1/NUM_RD=4 instance
// share stimulus; an array model is checked every cycle plus directed literals.
module tb_regfile_mp;
  localparam int DW = 36, D = 32, AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr_start = 1'b0;
  logic          wr0_en = 1'b0, wr1_en = 1'b0, res_en = 1'b0;
  logic [AW-1:0] wr0_addr = '0, wr1_addr = '0, res_addr = '0;
  logic [DW-1:0] wr0_data = '0, wr1_data = '0;
  logic [AW-1:0] ra [4];

  logic [2*AW-1:0] rd_addr_a;
  logic [4*AW-1:0] rd_addr_b;
  logic            ready_a, ready_b;
  logic [2*DW-1:0] rd_data_a;
  logic [4*DW-1:0] rd_data_b;
  logic [1:0]      rd_busy_a;
  logic [3:0]      rd_busy_b;
  logic [D-1:0]    busy_vec_a, busy_vec_b;

  assign rd_addr_a = {ra[1], ra[0]};
  assign rd_addr_b = {ra[3], ra[2], ra[1], ra[0]};

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .DEPTH(D), .NUM_RD(2), .ZERO_REG(0)) dut_a (
    .clk(clk), .rst(rst), .clr_start(clr_start), .ready(ready_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .res_en(res_en), .res_addr(res_addr), .busy_vec(busy_vec_a));

  regfile_mp #(.DATA_W(DW), .DEPTH(D), .NUM_RD(4), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst(rst), .clr_start(clr_start), .ready(ready_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .res_en(res_en), .res_addr(res_addr), .busy_vec(busy_vec_b));

  int n_pass = 0, n_chk = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
  endtask

  // Model: k=0 default instance, k=1 zero-register instance.
  logic [DW-1:0] mm [2][D];
  logic [D-1:0]  mb [2];
  int            clear_left = D;

  initial begin
    for (int k = 0; k < 2; k++) begin
      mb[k] = '0;
      for (int r = 0; r < D; r++) mm[k][r] = '0;
    end
  end

  function automatic logic keep(int k, logic [AW-1:0] a);
    return !(k == 1 && a == 0);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      clear_left <= D;
      mb[0] <= '0;
      mb[1] <= '0;
    end else if (clear_left != 0) begin
      clear_left <= clear_left - 1;
      if (clear_left == 1)
        for (int k = 0; k < 2; k++)
          for (int r = 0; r < D; r++) mm[k][r] <= '0;
    end else if (clr_start) begin
      clear_left <= D;
      mb[0] <= '0;
      mb[1] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        // Writebacks release, then a reservation (later NBA) re-marks busy.
        if (wr0_en && keep(k, wr0_addr)) begin mm[k][wr0_addr] <= wr0_data; mb[k][wr0_addr] <= 1'b0; end
        if (wr1_en && keep(k, wr1_addr)) begin mm[k][wr1_addr] <= wr1_data; mb[k][wr1_addr] <= 1'b0; end
        if (res_en && keep(k, res_addr)) mb[k][res_addr] <= 1'b1;
      end
    end
  end

  function automatic logic [DW-1:0] exp_data(int k, logic [AW-1:0] a);
    if (clear_left != 0 || !keep(k, a)) return '0;
    if (wr1_en && wr1_addr == a) return wr1_data;
    if (wr0_en && wr0_addr == a) return wr0_data;
    return mm[k][a];
  endfunction

  function automatic logic exp_busy(int k, logic [AW-1:0] a);
    if (clear_left != 0) return 1'b0;
    return mb[k][a] && !((wr1_en && wr1_addr == a) || (wr0_en && wr0_addr == a));
  endfunction

  always @(negedge clk) begin
    chk("ready_a", ready_a, clear_left == 0);
    chk("ready_b", ready_b, clear_left == 0);
    chk("busy_vec_a", busy_vec_a, mb[0]);
    chk("busy_vec_b", busy_vec_b, mb[1]);
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("rd_data_a[%0d]", p), rd_data_a[p*DW +: DW], exp_data(0, ra[p]));
      chk($sformatf("rd_busy_a[%0d]", p), rd_busy_a[p], exp_busy(0, ra[p]));
    end
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("rd_data_b[%0d]", p), rd_data_b[p*DW +: DW], exp_data(1, ra[p]));
      chk($sformatf("rd_busy_b[%0d]", p), rd_busy_b[p], exp_busy(1, ra[p]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr0_en = 1'b0; wr1_en = 1'b0; res_en = 1'b0; clr_start = 1'b0;
  endtask

  task automatic set_ra(input logic [AW-1:0] a);
    for (int p = 0; p < 4; p++) ra[p] = a;
  endtask

  task automatic wait_ready(input string nm);
    for (int e = 1; e <= D; e++) begin
      tick();
      if (e == D - 1) begin chk({nm, "_ready_low"}, ready_a, 1'b0); chk({nm, "_ready_low_b"}, ready_b, 1'b0); end
      if (e == D)     begin chk({nm, "_ready_high"}, ready_a, 1'b1); chk({nm, "_ready_high_b"}, ready_b, 1'b1); end
    end
  endtask

  initial begin
    rst = 1'b1;
    set_ra('0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Power-up clear
    wait_ready("por");
    for (int a = 0; a < D; a++) begin
      set_ra(AW'(a));
      #2;
      chk("por_read_a", rd_data_a[DW-1:0], '0);
      chk("por_read_b", rd_data_b[3*DW +: DW], '0);
      tick();
    end
    chk("por_busy", busy_vec_a, '0);

    // Write bypass then storage
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 36'h123456789; ra[0] = 5'd5;
    #2 chk("bypass_r5", rd_data_a[DW-1:0], 36'h123456789);
    tick(); idle();
    #2 chk("stored_r5", rd_data_a[DW-1:0], 36'h123456789);
    tick();

    // Write-port priority and dual commit
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 36'hAAA;
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 36'hBBB; ra[0] = 5'd7;
    #2 chk("prio_bypass_r7", rd_data_a[DW-1:0], 36'hBBB);
    tick(); idle();
    #2 chk("prio_stored_r7", rd_data_a[DW-1:0], 36'hBBB);
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 36'h1;
    wr1_en = 1'b1; wr1_addr = 5'd4; wr1_data = 36'h2;
    tick(); idle();
    ra[0] = 5'd3; ra[1] = 5'd4;
    #2 chk("dual_r3", rd_data_a[DW-1:0], 36'h1);
    chk("dual_r4", rd_data_a[DW +: DW], 36'h2);
    tick();

    // Scoreboard
    res_en = 1'b1; res_addr = 5'd9;
    tick(); idle();
    ra[0] = 5'd9;
    #2 chk("res_r9", busy_vec_a[9], 1'b1);
    chk("rd_busy_r9", rd_busy_a[0], 1'b1);
    wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 36'h55;
    #2 chk("wb_rd_busy_r9", rd_busy_a[0], 1'b0);
    chk("wb_bypass_r9", rd_data_a[DW-1:0], 36'h55);
    tick(); idle();
    #2 chk("released_r9", busy_vec_a[9], 1'b0);
    res_en = 1'b1; res_addr = 5'd9; wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 36'h66;
    tick(); idle();
    #2 chk("res_over_wb_r9", busy_vec_a[9], 1'b1);
    chk("res_over_wb_data", rd_data_a[DW-1:0], 36'h66);
    tick();

    // Zero register and four read ports
    wr0_en = 1'b1; wr0_addr = 5'd1; wr0_data = 36'h11;
    wr1_en = 1'b1; wr1_addr = 5'd2; wr1_data = 36'h22;
    tick(); idle();
    wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 36'hFFF; res_en = 1'b1; res_addr = 5'd0;
    ra[0] = 5'd0; ra[1] = 5'd1; ra[2] = 5'd2; ra[3] = 5'd0;
    #2 chk("zr_no_bypass", rd_data_b[DW-1:0], '0);
    chk("r0_bypass_a", rd_data_a[DW-1:0], 36'hFFF);
    tick(); idle();
    #2 chk("zr_busy0", busy_vec_b[0], 1'b0);
    chk("r0_busy_a", busy_vec_a[0], 1'b1);
    chk("zr_p0", rd_data_b[0*DW +: DW], '0);
    chk("zr_p1", rd_data_b[1*DW +: DW], 36'h11);
    chk("zr_p2", rd_data_b[2*DW +: DW], 36'h22);
    chk("zr_p3", rd_data_b[3*DW +: DW], '0);
    tick();

    // Requested clear with hostile inputs during the sequence
    clr_start = 1'b1;
    tick(); idle();
    #2 chk("clr_ready", ready_a, 1'b0);
    chk("clr_busy", busy_vec_a, '0);
    for (int i = 0; i < D; i++) begin
      wr0_en = 1'b1; wr0_addr = AW'($urandom_range(D-1, 0)); wr0_data = DW'($urandom());
      wr1_en = 1'b1; wr1_addr = AW'($urandom_range(D-1, 0)); wr1_data = DW'($urandom());
      res_en = 1'b1; res_addr = AW'($urandom_range(D-1, 0));
      clr_start = 1'b1;
      #2 if (i == D - 1) chk("clr_still_low", ready_a, 1'b0);
      tick();
    end
    idle();
    #2 chk("clr_done", ready_a, 1'b1);
    chk("clr_done_busy", busy_vec_a, '0);
    for (int a = 0; a < D; a++) begin
      set_ra(AW'(a));
      #2 chk("clr_read_a", rd_data_a[DW +: DW], '0);
      tick();
    end

    // Reset in the middle of a clear restarts it from address 0
    wr0_en = 1'b1; wr0_addr = 5'd20; wr0_data = 36'hABC;
    tick(); idle();
    clr_start = 1'b1;
    tick(); idle();
    repeat (10) tick();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    wait_ready("mid_rst");
    ra[0] = 5'd20;
    #2 chk("mid_rst_r20", rd_data_a[DW-1:0], '0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised scalar register file for the core's decode/issue stage.
- Provides NUM_RD combinational read ports with write-bypass and two write ports with fixed priority.
- Holds a per-register busy scoreboard (reserve on issue, release on writeback).
- Runs a hardware clear sequencer that zeroes every entry after reset or on request; `ready` is low until the clear completes.

Parameters:
DATA_W, 36, register width in bits
DEPTH, 32, number of registers
ADDR_W, $clog2(DEPTH), register address width
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 0, when 1: register 0 always reads 0, is never busy, and ignores writes and reservations

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous active-high reset
clr_start  in  1  pulse in READY starts a full clear sequence
ready  out  1  high when the file is usable (state READY)
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i at [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data, combinational
rd_busy  out  NUM_RD  busy flag of the addressed register, combinational
wr0_en  in  1  write port 0 enable
wr0_addr  in  ADDR_W  write port 0 address
wr0_data  in  DATA_W  write port 0 data
wr1_en  in  1  write port 1 enable (higher priority)
wr1_addr  in  ADDR_W  write port 1 address
wr1_data  in  DATA_W  write port 1 data
res_en  in  1  reserve: mark res_addr busy
res_addr  in  ADDR_W  register to reserve
busy_vec  out  DEPTH  full scoreboard, registered

Behaviour:
- Reset (rst=1, asynchronous):
  - state=CLEAR, clear pointer=0, ready=0, busy_vec=0.
  - Storage has no reset; the sequencer zeroes it.
  - Reset asserted mid-clear or mid-operation restarts the clear from address 0.
- States:
  - CLEAR: each edge writes 0 to mem[ptr], then ptr++. On the edge where ptr==DEPTH-1, go to READY and set ready=1. ready therefore rises after exactly DEPTH edges following reset release.
  - READY: normal operation. clr_start=1 goes to CLEAR at the next edge with ptr=0, ready=0, busy_vec=0.
- In CLEAR:
  - wr*_en and res_en are ignored; rd_data=0 and rd_busy=0 on all ports.
  - clr_start is ignored.
- Writes (READY only):
  - mem[wrN_addr] <= wrN_data at the edge.
  - Both ports enabled to the same address: wr1 wins, wr0 is dropped.
  - Different addresses: both commit.
- Reads (READY only):
  - Read port i is combinational.
  - If wr1_en and wr1_addr==rd_addr[i], return wr1_data.
  - Else if wr0_en and wr0_addr==rd_addr[i], return wr0_data.
  - Else return mem[rd_addr[i]].
  - Any number of ports may read the same address.
- Scoreboard (READY only), next-state per bit r:
  - set if res_en and res_addr==r;
  - else cleared if any enabled write targets r;
  - else hold.
  - Reserve and write to the same register in one cycle leaves it busy (a new producer overrides the release).
- rd_busy[i] = busy_vec[rd_addr[i]] & ~(any enabled write to rd_addr[i] this cycle). A same-cycle writeback is seen as not busy, consistent with the bypass.
- ZERO_REG=1: writes and reservations to address 0 are dropped; rd_data for address 0 is 0 with no bypass; busy_vec[0] is always 0.
- Addresses >= DEPTH (non-power-of-2 DEPTH):
  - Writes and reservations are dropped.
  - Reads return 0, rd_busy=0.
- No X on outputs after reset release; rd_data is 0 during CLEAR.

Test Plan:
1. Reset, DEPTH=32 -> ready=0 for 32 edges after rst falls and 1 after the 32nd. Then read every address -> 0; busy_vec=0.
2. Write 0x123456789 to r5 via wr0 while read port 0 reads r5 in the same cycle -> rd_data0=0x123456789 that cycle (bypass). Next cycle, with wr0_en=0 -> rd_data0=0x123456789 from storage.
3. Same cycle wr0 (r7, 0xAAA) and wr1 (r7, 0xBBB) -> rd_data=0xBBB same cycle and afterwards. Same cycle wr0 r3=1 and wr1 r4=2 -> both stored.
4. Scoreboard:
   - res_en r9 -> busy_vec[9]=1 next cycle.
   - Read r9 with wr1 writing r9 that cycle -> rd_busy=0, bypass data returned; next cycle busy_vec[9]=0.
   - res_en and wr0 both on r9 in one cycle -> busy_vec[9]=1 after.
5. ZERO_REG=1: write 0xFFF to r0 and res_en r0 -> rd_data=0, busy_vec[0]=0. With NUM_RD=4, all ports read r0/r1/r2/r0 correctly.
6. Scenario 5 first fills registers with data. Then:
   - clr_start -> ready=0 and busy_vec=0 next edge; wr/res inputs ignored for 32 cycles; ready=1; all reads 0.
   - Assert rst at clear pointer 10 -> sequence restarts, ready after 32 edges from release.
